vga_timing_rx: RTL and testbench

Receiver end of the VGA timing generator. It sits on the pixel clock, consumes hsync/vsync/de as produced by vga_core, and recovers the active-area pixel and line position. It also measures the frame geometry and reports lock once the geometry has been stable for several frames. It is used for loopback self-test of the video path and for capture blocks that need coordinates from raw sync.

---
 rtl/vga_rx_pkg.sv | 24 ++
 rtl/vga_timing_rx_sync_edge_det.sv | 28 ++
 rtl/vga_timing_rx.sv | 216 +++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and reference constants for the VGA timing receiver.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    localparam int SNAP_W = 16;

    typedef struct packed {
        logic [SNAP_W-1:0] h_active;
        logic [SNAP_W-1:0] v_active;
        logic [SNAP_W-1:0] h_total;
        logic [SNAP_W-1:0] v_total;
    } snapshot_t;

    localparam int REF_H_TOTAL  = 800;
    localparam int REF_V_TOTAL  = 525;
    localparam int REF_H_ACTIVE = 640;
    localparam int REF_V_ACTIVE = 480;

endpackage

// File: rtl/vga_timing_rx_sync_edge_det.sv
// One register stage on a raw timing input, normalised so that 1 means
// "asserted", with single-cycle pulses on the asserting and releasing edges.
module sync_edge_det #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= ACTIVE_HIGH ? din : ~din;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/vga_timing_rx.sv
// Recovers active-area pixel/line coordinates from raw hsync/vsync/de and
// measures frame geometry, asserting locked_o once it has been stable.
module vga_timing_rx
    import vga_rx_pkg::*;
#(
    parameter int HSZ         = 10,
    parameter int VSZ         = 9,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    input  logic           de_i,
    output logic           de_o,
    output logic [HSZ-1:0] hcount_o,
    output logic [VSZ-1:0] vcount_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic [HSZ-1:0] h_active_o,
    output logic [VSZ-1:0] v_active_o,
    output logic [HSZ:0]   h_total_o,
    output logic [VSZ:0]   v_total_o,
    output logic           locked_o
);
    localparam logic [HSZ-1:0] H_MAX        = '1;
    localparam logic [HSZ:0]   HT_MAX       = '1;
    localparam logic [VSZ-1:0] V_MAX        = '1;
    localparam logic [VSZ:0]   VT_MAX       = '1;
    localparam logic [3:0]     LOCK_MATCHES = 4'(LOCK_FRAMES - 1);

    logic hs_lvl, hs_lead, hs_fall;
    logic vs_lvl, vs_lead, vs_fall;
    logic de_lvl, de_rise, de_fall;
    logic unused_edges;

    sync_edge_det #(.ACTIVE_HIGH(SYNC_POL)) u_hs_det (
        .clk(clk_i), .rst(rst_i), .din(hsync_i),
        .level(hs_lvl), .rise(hs_lead), .fall(hs_fall)
    );
    sync_edge_det #(.ACTIVE_HIGH(SYNC_POL)) u_vs_det (
        .clk(clk_i), .rst(rst_i), .din(vsync_i),
        .level(vs_lvl), .rise(vs_lead), .fall(vs_fall)
    );
    sync_edge_det #(.ACTIVE_HIGH(1'b1)) u_de_det (
        .clk(clk_i), .rst(rst_i), .din(de_i),
        .level(de_lvl), .rise(de_rise), .fall(de_fall)
    );

    assign unused_edges = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

    logic first_pending, pending_now;

    // A de edge coinciding with the vsync leading edge opens the new frame.
    assign pending_now = first_pending | vs_lead;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_o          <= 1'b0;
            hcount_o      <= '0;
            vcount_o      <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            first_pending <= 1'b0;
        end else begin
            de_o          <= de_lvl;
            line_start_o  <= de_rise;
            frame_start_o <= de_rise & pending_now;
            if (de_rise)
                hcount_o <= '0;
            else if (de_lvl && hcount_o != H_MAX)
                hcount_o <= hcount_o + 1'b1;
            if (de_rise) begin
                if (pending_now)
                    vcount_o <= '0;
                else if (vcount_o != V_MAX)
                    vcount_o <= vcount_o + 1'b1;
            end
            if (de_rise)
                first_pending <= 1'b0;
            else if (vs_lead)
                first_pending <= 1'b1;
        end
    end

    logic [HSZ:0]   hclk, h_total_r;
    logic [HSZ-1:0] hact, hact_last;
    logic [VSZ:0]   hlines;
    logic [VSZ-1:0] vlines;
    logic           hact_seen, incons;
    logic           hclk_sat, hact_sat, hlines_sat, vlines_sat, any_sat, timeout;

    assign hclk_sat   = (hclk == HT_MAX);
    assign hact_sat   = (hact == H_MAX);
    assign hlines_sat = (hlines == VT_MAX);
    assign vlines_sat = (vlines == V_MAX);
    assign any_sat    = hclk_sat | hact_sat | hlines_sat | vlines_sat;
    assign timeout    = hclk_sat | hlines_sat;

    // An hsync leading edge on the vsync edge is counted in the new frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hclk      <= '0;
            h_total_r <= '0;
            hact      <= '0;
            hact_last <= '0;
            hlines    <= '0;
            vlines    <= '0;
            hact_seen <= 1'b0;
            incons    <= 1'b0;
        end else begin
            if (hs_lead) begin
                h_total_r <= hclk;
                hclk      <= (HSZ+1)'(1);
            end else if (!hclk_sat) begin
                hclk <= hclk + 1'b1;
            end
            if (de_rise)
                hact <= HSZ'(1);
            else if (de_lvl && !hact_sat)
                hact <= hact + 1'b1;
            if (de_fall)
                hact_last <= hact;
            if (vs_lead) begin
                hlines    <= {{VSZ{1'b0}}, hs_lead};
                vlines    <= {{(VSZ-1){1'b0}}, de_rise};
                incons    <= 1'b0;
                hact_seen <= de_fall;
            end else begin
                if (hs_lead && !hlines_sat)
                    hlines <= hlines + 1'b1;
                if (de_rise && !vlines_sat)
                    vlines <= vlines + 1'b1;
                if ((de_fall && hact_seen && hact != hact_last) || any_sat)
                    incons <= 1'b1;
                if (de_fall)
                    hact_seen <= 1'b1;
            end
        end
    end

    snapshot_t snap, snap_new;
    rx_state_t state, state_n;
    logic [3:0] match_cnt, match_n, match_inc;
    logic       same;
    logic       unused_snap;

    assign snap_new.h_active = SNAP_W'(hact_last);
    assign snap_new.v_active = SNAP_W'(vlines);
    assign snap_new.h_total  = SNAP_W'(h_total_r);
    assign snap_new.v_total  = SNAP_W'(hlines);

    assign same      = (snap_new == snap) && !incons && !any_sat;
    assign match_inc = match_cnt + 4'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= SEARCH;
            match_cnt <= '0;
            snap      <= '0;
        end else begin
            state     <= state_n;
            match_cnt <= match_n;
            if (vs_lead && !timeout)
                snap <= snap_new;
        end
    end

    // The first snapshot of an equal run is the reference, so a run of
    // LOCK_FRAMES equal snapshots needs LOCK_FRAMES-1 matches.
    always_comb begin
        state_n = state;
        match_n = match_cnt;
        if (timeout) begin
            state_n = SEARCH;
            match_n = '0;
        end else if (vs_lead) begin
            unique case (state)
                SEARCH: begin
                    state_n = MEASURE;
                    match_n = '0;
                end
                MEASURE: begin
                    if (same) begin
                        match_n = match_inc;
                        if (match_inc >= LOCK_MATCHES)
                            state_n = LOCKED;
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        state_n = MEASURE;
                        match_n = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                    match_n = '0;
                end
            endcase
        end
    end

    assign locked_o   = (state == LOCKED);
    assign h_active_o = snap.h_active[HSZ-1:0];
    assign v_active_o = snap.v_active[VSZ-1:0];
    assign h_total_o  = snap.h_total[HSZ:0];
    assign v_total_o  = snap.v_total[VSZ:0];

    assign unused_snap = ^{snap.h_active[SNAP_W-1:HSZ], snap.v_active[SNAP_W-1:VSZ],
                           snap.h_total[SNAP_W-1:HSZ+1], snap.v_total[SNAP_W-1:VSZ+1]};

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx using a compact 24x16 raster so that
// locking, glitch, sync-loss and reset scenarios fit in a short run.
module tb_vga_timing_rx;
    localparam int H_ACT   = 16;
    localparam int H_FP    = 2;
    localparam int H_SYNC  = 4;
    localparam int H_TOT   = 24;
    localparam int V_ACT   = 10;
    localparam int V_FP    = 2;
    localparam int V_SYNC  = 2;
    localparam int V_TOT   = 16;
    localparam int VS_LINE = V_ACT + V_FP;
    localparam int HS_PIX  = H_ACT + H_FP;

    typedef struct packed {
        logic [9:0] h;
        logic [8:0] v;
        logic       ls;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst, rst_p;
    logic hsync, vsync, de, hsync_p, vsync_p;

    logic       de_o, line_start, frame_start, locked;
    logic [9:0] hcount, h_active, v_total;
    logic [8:0] vcount, v_active;
    logic [10:0] h_total;

    logic       p_de_o, p_line_start, p_frame_start, p_locked;
    logic [9:0] p_hcount, p_h_active, p_v_total;
    logic [8:0] p_vcount, p_v_active;
    logic [10:0] p_h_total;

    pix_t exp_q[$];
    pix_t got_exp;
    int   vectors = 0;
    int   miscompares = 0;
    int   ls_seen = 0;
    int   fs_seen = 0;
    bit   mon_en = 1'b0;
    logic lock_pre, lock_post;

    vga_timing_rx #(.HSZ(10), .VSZ(9), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
        .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
        .de_o(de_o), .hcount_o(hcount), .vcount_o(vcount),
        .line_start_o(line_start), .frame_start_o(frame_start),
        .h_active_o(h_active), .v_active_o(v_active),
        .h_total_o(h_total), .v_total_o(v_total), .locked_o(locked)
    );

    vga_timing_rx #(.HSZ(10), .VSZ(9), .SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut_p (
        .clk_i(clk), .rst_i(rst_p), .hsync_i(hsync_p), .vsync_i(vsync_p), .de_i(de),
        .de_o(p_de_o), .hcount_o(p_hcount), .vcount_o(p_vcount),
        .line_start_o(p_line_start), .frame_start_o(p_frame_start),
        .h_active_o(p_h_active), .v_active_o(p_v_active),
        .h_total_o(p_h_total), .v_total_o(p_v_total), .locked_o(p_locked)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every active output pixel is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && de_o) begin
            if (line_start)  ls_seen++;
            if (frame_start) fs_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected de_o", 1, 0);
            end else begin
                got_exp = exp_q.pop_front();
                checkOutput("hcount", hcount, got_exp.h);
                checkOutput("vcount", vcount, got_exp.v);
                checkOutput("line_start", line_start, got_exp.ls);
                checkOutput("frame_start", frame_start, got_exp.fs);
            end
        end
    end

    // One raster frame; the coincident-edge instance sees vsync starting on
    // the hsync leading edge with active-high polarity.
    task automatic applyStimulus(input bit vs_on, input int glitch_line,
                                 input int rst_line, input int rst_pix,
                                 input bit push, input bit fresh);
        pix_t e;
        bit   hs_on, vs_std, vs_co, de_on;
        int   pos;
        for (int l = 0; l < V_TOT; l++) begin
            for (int p = 0; p < H_TOT; p++) begin
                @(negedge clk);
                if (l == VS_LINE && p == 1) lock_pre  = locked;
                if (l == VS_LINE && p == 2) lock_post = locked;
                if (l == rst_line && p == rst_pix) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("async reset de_o", de_o, 0);
                    checkOutput("async reset hcount", hcount, 0);
                    checkOutput("async reset vcount", vcount, 0);
                    checkOutput("async reset h_active", h_active, 0);
                    checkOutput("async reset h_total", h_total, 0);
                    checkOutput("async reset v_total", v_total, 0);
                    exp_q.delete();
                end
                if (l == rst_line && p == rst_pix + 3) rst = 1'b0;
                pos    = l * H_TOT + p;
                hs_on  = (p >= HS_PIX) && (p < HS_PIX + H_SYNC);
                vs_std = vs_on && (l >= VS_LINE) && (l < VS_LINE + V_SYNC);
                vs_co  = vs_on && (pos >= VS_LINE * H_TOT + HS_PIX)
                               && (pos < (VS_LINE + V_SYNC) * H_TOT + HS_PIX);
                de_on  = (l < V_ACT) && (p < H_ACT) && !(l == glitch_line && p == H_ACT - 1);
                hsync   = ~hs_on;
                vsync   = ~vs_std;
                hsync_p = hs_on;
                vsync_p = vs_co;
                de      = de_on;
                if (push && de_on) begin
                    e.h  = 10'(p);
                    e.v  = fresh ? 9'(l + 1) : 9'(l);
                    e.ls = (p == 0);
                    e.fs = (p == 0) && (l == 0) && !fresh;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst_p = 1'b1;
        hsync = 1'b1; vsync = 1'b1; de = 1'b0; hsync_p = 1'b0; vsync_p = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset de_o", de_o, 0);
        checkOutput("reset hcount", hcount, 0);
        checkOutput("reset vcount", vcount, 0);
        checkOutput("reset frame_start", frame_start, 0);
        checkOutput("reset h_total", h_total, 0);
        checkOutput("reset v_active", v_active, 0);
        checkOutput("reset locked", locked, 0);
        rst = 1'b0; rst_p = 1'b0;
        mon_en = 1'b1;

        $display("[TB] clean frames, lock acquisition");
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b1);
        checkOutput("F1 partial v_total", v_total, 12);
        checkOutput("F1 locked", lock_post, 0);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("F2 h_total", h_total, H_TOT);
        checkOutput("F2 v_total", v_total, V_TOT);
        checkOutput("F2 h_active", h_active, H_ACT);
        checkOutput("F2 v_active", v_active, V_ACT);
        checkOutput("F2 locked", lock_post, 0);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("F3 locked on vsync edge", lock_pre, 0);
        checkOutput("F3 locked one cycle later", lock_post, 1);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("F4 locked", lock_post, 1);
        checkOutput("line_start count", ls_seen, 4 * V_ACT);
        checkOutput("frame_start count", fs_seen, 3);
        checkOutput("pol1 v_total", p_v_total, V_TOT);
        checkOutput("pol1 h_total", p_h_total, H_TOT);
        checkOutput("pol1 locked", p_locked, 1);

        $display("[TB] short de run while locked");
        applyStimulus(1'b1, V_ACT - 1, -1, 0, 1'b1, 1'b0);
        checkOutput("F5 locked on vsync edge", lock_pre, 1);
        checkOutput("F5 locked dropped", lock_post, 0);
        checkOutput("F5 h_active", h_active, H_ACT - 1);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("F6 locked", lock_post, 0);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("F7 relocked", lock_post, 1);
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("[TB] vsync removed");
        mon_en = 1'b0;
        for (int f = 0; f < 60; f++) applyStimulus(1'b0, -1, -1, 0, 1'b0, 1'b0);
        checkOutput("lock held before hlines saturates", locked, 1);
        for (int f = 0; f < 4; f++) applyStimulus(1'b0, -1, -1, 0, 1'b0, 1'b0);
        checkOutput("timeout locked", locked, 0);
        checkOutput("timeout h_active held", h_active, H_ACT);
        checkOutput("timeout h_total held", h_total, H_TOT);
        checkOutput("timeout v_total held", v_total, V_TOT);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, -1, 5, 10, 1'b0, 1'b0);
        mon_en = 1'b1;
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("R1 locked", lock_post, 0);
        checkOutput("R1 v_total", v_total, V_TOT);
        applyStimulus(1'b1, -1, -1, 0, 1'b1, 1'b0);
        checkOutput("R2 relocked", lock_post, 1);
        checkOutput("R2 h_active", h_active, H_ACT);
        checkOutput("final scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
